// File: rtl/iv_port_responder.sv
// iv_port_responder: addressable 8-bit I/O port on the CPU IV bus, peripheral side.
module iv_port_responder #(
    parameter logic [7:0] ADDR          = 8'h00,
    parameter bit         CLEAR_ON_READ = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] iv,
    input  logic       bank_n,
    input  logic       sc,
    input  logic       wc,
    input  logic       mclk,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       selected
);
    typedef enum logic {R_IDLE, R_DRIVE} rstate_t;
    rstate_t state, state_nx;
    logic [7:0] d, enc, rd_reg;
    logic sample, addr_cyc, wr_cyc, drive, read_done, load, rd_full;
    // Bus is active-low and bit-reversed in both directions.
    always_comb begin
        d = 8'h00;
        enc = 8'h00;
        for (int k = 0; k < 8; k++) begin
            d[7-k] = ~iv[k];
            enc[k] = ~rd_reg[7-k];
        end
    end
    assign sample   = mclk && !bank_n;
    assign addr_cyc = sample && sc;
    assign wr_cyc   = sample && wc && !sc && selected;
    assign drive    = !bank_n && !sc && !wc && selected;
    assign load     = in_valid && !rd_full;
    assign in_ready = !rd_full;
    assign iv       = drive ? enc : 8'hzz;
    always_ff @(posedge clk) begin
        if (!reset) state <= R_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == R_IDLE && drive) state_nx = R_DRIVE;
        else if (state == R_DRIVE && (bank_n || sc || wc)) state_nx = R_IDLE;
    end
    // A strobe while still banked is the RMW write phase, so it also ends the read.
    always_comb read_done = (state == R_DRIVE) && (bank_n || sc || wc);
    always_ff @(posedge clk) begin
        if (!reset) begin
            selected  <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (addr_cyc) selected <= (d == ADDR);
            if (wr_cyc) begin
                out_data  <= d;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_reg  <= 8'h00;
            rd_full <= 1'b0;
        end else begin
            if (read_done && CLEAR_ON_READ) rd_full <= 1'b0;
            if (load) begin
                rd_reg  <= in_data;
                rd_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iv_port_responder.sv
// tb_iv_port_responder: directed checks of two ports (clear-on-read and non-destructive).
module tb_iv_port_responder;
    logic clk = 1'b0;
    logic reset, bank_n, sc, wc, mclk, out_ready, in_valid, tb_en;
    logic [7:0] in_data, tb_val;
    wire  [7:0] iv0, iv1;
    logic [7:0] out_data0, out_data1;
    logic out_valid0, out_valid1, overrun0, overrun1, in_ready0, in_ready1, selected0, selected1;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    assign iv0 = tb_en ? tb_val : 8'hzz;
    assign iv1 = tb_en ? tb_val : 8'hzz;

    iv_port_responder #(.ADDR(8'h12), .CLEAR_ON_READ(1'b1)) dut0 (
        .clk(clk), .reset(reset), .iv(iv0), .bank_n(bank_n), .sc(sc), .wc(wc), .mclk(mclk),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .overrun(overrun0),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0), .selected(selected0));

    iv_port_responder #(.ADDR(8'h12), .CLEAR_ON_READ(1'b0)) dut1 (
        .clk(clk), .reset(reset), .iv(iv1), .bank_n(bank_n), .sc(sc), .wc(wc), .mclk(mclk),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .overrun(overrun1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1), .selected(selected1));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bank_n = 1'b1; mclk = 1'b0; sc = 1'b0; wc = 1'b0; tb_en = 1'b0;
    endtask

    // One sampled bus cycle (address or write) with the CPU driving iv.
    task automatic bus(input logic s, input logic w, input logic [7:0] v);
        bank_n = 1'b0; mclk = 1'b1; sc = s; wc = w; tb_en = 1'b1; tb_val = v;
        tick();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00; tb_val = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_sel", {7'd0, selected0}, 8'd0);
        chk("rst_val", {7'd0, out_valid0}, 8'd0);
        chk("rst_ovr", {7'd0, overrun0}, 8'd0);
        chk("rst_inr", {7'd0, in_ready0}, 8'd1);
        chk("rst_dat", out_data0, 8'h00);

        bus(1'b1, 1'b0, 8'hB7);
        chk("sel_hit", {7'd0, selected0}, 8'd1);
        bus(1'b1, 1'b0, 8'hFF);
        chk("sel_miss", {7'd0, selected0}, 8'd0);
        bus(1'b0, 1'b1, 8'h7F);
        chk("wr_unsel", {7'd0, out_valid0}, 8'd0);
        bus(1'b1, 1'b1, 8'hB7);
        chk("sc_wc_sel", {7'd0, selected0}, 8'd1);
        chk("sc_wc_nowr", {7'd0, out_valid0}, 8'd0);

        bus(1'b0, 1'b1, 8'h7F);
        chk("wr1_dat", out_data0, 8'h01);
        chk("wr1_val", {7'd0, out_valid0}, 8'd1);
        chk("wr1_ovr", {7'd0, overrun0}, 8'd0);
        bus(1'b0, 1'b1, 8'hFE);
        chk("wr2_dat", out_data0, 8'h80);
        chk("wr2_ovr", {7'd0, overrun0}, 8'd1);

        do_reset();
        chk("rst2_ovr", {7'd0, overrun0}, 8'd0);
        bus(1'b1, 1'b0, 8'hB7);
        bus(1'b0, 1'b1, 8'h7F);
        out_ready = 1'b1;
        bus(1'b0, 1'b1, 8'hC3);
        chk("hs_dat", out_data0, 8'h3C);
        chk("hs_val", {7'd0, out_valid0}, 8'd1);
        chk("hs_ovr", {7'd0, overrun0}, 8'd0);
        tick();
        chk("hs_drain", {7'd0, out_valid0}, 8'd0);
        out_ready = 1'b0;

        in_data = 8'hA0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ld_inr0", {7'd0, in_ready0}, 8'd0);
        chk("ld_inr1", {7'd0, in_ready1}, 8'd0);
        bank_n = 1'b0;
        #1;
        chk("rd_iv0", iv0, 8'hFA);
        chk("rd_iv1", iv1, 8'hFA);
        tick();
        tick();
        bank_n = 1'b1;
        tick();
        chk("cor_inr0", {7'd0, in_ready0}, 8'd1);
        chk("ncor_inr1", {7'd0, in_ready1}, 8'd0);

        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ld2_inr0", {7'd0, in_ready0}, 8'd0);
        chk("ld2_keep1", iv1 === 8'hzz ? 8'd1 : 8'd0, 8'd1);
        bank_n = 1'b0;
        tick();
        wc = 1'b1;
        #1;
        chk("rmw_hiz", iv0 === 8'hzz ? 8'd1 : 8'd0, 8'd1);
        tick();
        idle();
        chk("rmw_done", {7'd0, in_ready0}, 8'd1);

        bus(1'b1, 1'b0, 8'hFF);
        bank_n = 1'b0;
        #1;
        chk("unsel_hiz", iv0 === 8'hzz ? 8'd1 : 8'd0, 8'd1);
        idle();
        bus(1'b0, 1'b1, 8'h00);
        chk("unsel_wr", {7'd0, out_valid0}, 8'd0);

        bus(1'b1, 1'b0, 8'hB7);
        bus(1'b0, 1'b1, 8'h7F);
        bus(1'b0, 1'b1, 8'hFE);
        chk("pre_ovr", {7'd0, overrun0}, 8'd1);
        in_data = 8'h33; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bank_n = 1'b0;
        tick();
        chk("pre_iv", iv0, 8'h33);
        reset = 1'b0;
        tick();
        chk("mid_hiz", iv0 === 8'hzz ? 8'd1 : 8'd0, 8'd1);
        chk("mid_sel", {7'd0, selected0}, 8'd0);
        chk("mid_inr", {7'd0, in_ready0}, 8'd1);
        chk("mid_val", {7'd0, out_valid0}, 8'd0);
        chk("mid_ovr", {7'd0, overrun0}, 8'd0);
        chk("mid_dat", out_data0, 8'h00);
        reset = 1'b1;
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
